// File: rtl/wc_tile_feeder.sv
// ----------------------------------------------------------------------------
// wc_tile_feeder
// Transmit side of the WC (Winograd F(5,3)) tile interface. Packs a serial
// stream of signed samples into overlapping TILE-sample tiles with a stride
// of STEP samples, so consecutive tiles share TILE-STEP samples.
//
// Optional feature macro: WC_FEED_ZPAD_EN
//   undefined : a partial tile at s_last is discarded and drop_pulse fires
//   defined   : a partial tile at s_last is zero-padded and sent as last tile
//
// Ports
//   clk        : clock, rising edge
//   rst        : synchronous active-low reset (0 = reset)
//   s_valid    : input sample valid
//   s_ready    : feeder accepts the sample this cycle (registered)
//   s_data     : input sample, DW bits two's complement
//   s_last     : final sample of a sequence
//   tile_valid : D holds a complete tile (registered)
//   tile_ready : consumer takes the tile this cycle
//   D          : tile, oldest sample in the top field, newest in D[DW-1:0]
//   tile_last  : tile is the final tile of its sequence
//   drop_pulse : one-cycle pulse when a partial tile is discarded
// ----------------------------------------------------------------------------
module wc_tile_feeder #(
   parameter int DW   = 10,
   parameter int TILE = 7,
   parameter int STEP = 5
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               s_valid,
   output logic               s_ready,
   input  logic [DW-1:0]      s_data,
   input  logic               s_last,
   output logic               tile_valid,
   input  logic               tile_ready,
   output logic [TILE*DW-1:0] D,
   output logic               tile_last,
   output logic               drop_pulse
);

   localparam int CW = $clog2(TILE + 1);
   localparam logic [CW-1:0] TILE_C = CW'(TILE);
   localparam logic [CW-1:0] STEP_C = CW'(STEP);

   typedef enum logic [1:0] {
      ST_FILL,
      ST_STEP,
      ST_HOLD,
      ST_PAD
   } state_t;

   state_t               state;
   logic [CW-1:0]        cnt;
   logic [CW-1:0]        cnt_inc;
   logic [CW-1:0]        target;
   logic [TILE*DW-1:0]   window;
   logic                 accept;

`ifdef WC_FEED_ZPAD_EN
   // Remembers whether the padded tile started in FILL (needs TILE samples)
   // or in STEP (needs STEP samples).
   logic                 pad_full;
`endif

   assign D       = window;
   assign accept  = s_valid & s_ready;
   assign cnt_inc = cnt + CW'(1);

   // Number of samples the current state must collect before a tile is ready.
   always_comb begin
      target = TILE_C;
      if (state == ST_STEP) begin
         target = STEP_C;
      end
`ifdef WC_FEED_ZPAD_EN
      if (state == ST_PAD && !pad_full) begin
         target = STEP_C;
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= ST_FILL;
         cnt        <= '0;
         window     <= '0;
         s_ready    <= 1'b0;
         tile_valid <= 1'b0;
         tile_last  <= 1'b0;
         drop_pulse <= 1'b0;
`ifdef WC_FEED_ZPAD_EN
         pad_full   <= 1'b0;
`endif
      end else begin
         drop_pulse <= 1'b0;
         unique case (state)
            ST_FILL, ST_STEP: begin
               s_ready <= 1'b1;
               if (accept) begin
                  window <= {window[(TILE-1)*DW-1:0], s_data};
                  if (cnt_inc == target) begin
                     // Completing sample: present the tile, stop accepting.
                     state      <= ST_HOLD;
                     cnt        <= '0;
                     s_ready    <= 1'b0;
                     tile_valid <= 1'b1;
                     tile_last  <= s_last;
                  end else if (s_last) begin
`ifdef WC_FEED_ZPAD_EN
                     state    <= ST_PAD;
                     cnt      <= cnt_inc;
                     s_ready  <= 1'b0;
                     pad_full <= (state == ST_FILL);
`else
                     // Partial tile is thrown away; the clear wins over the shift.
                     state      <= ST_FILL;
                     cnt        <= '0;
                     window     <= '0;
                     drop_pulse <= 1'b1;
`endif
                  end else begin
                     cnt <= cnt_inc;
                  end
               end
            end

            ST_HOLD: begin
               if (tile_ready) begin
                  tile_valid <= 1'b0;
                  tile_last  <= 1'b0;
                  s_ready    <= 1'b1;
                  cnt        <= '0;
                  if (tile_last) begin
                     state  <= ST_FILL;
                     window <= '0;
                  end else begin
                     // Window kept so the overlap samples carry into the next tile.
                     state <= ST_STEP;
                  end
               end
            end

            ST_PAD: begin
`ifdef WC_FEED_ZPAD_EN
               window <= {window[(TILE-1)*DW-1:0], {DW{1'b0}}};
               if (cnt_inc == target) begin
                  state      <= ST_HOLD;
                  cnt        <= '0;
                  tile_valid <= 1'b1;
                  tile_last  <= 1'b1;
               end else begin
                  cnt <= cnt_inc;
               end
`else
               state <= ST_FILL;
`endif
            end

            default: state <= ST_FILL;
         endcase
      end
   end

endmodule

// File: tb/tb_wc_tile_feeder.sv
// ----------------------------------------------------------------------------
// tb_wc_tile_feeder
// Directed self-checking bench for wc_tile_feeder. Expected tiles are built
// from hand-chosen sample values; the zero-pad expectations follow
// WC_FEED_ZPAD_EN the same way the design does.
// ----------------------------------------------------------------------------
module tb_wc_tile_feeder;

   logic        clk;
   logic        rst;
   logic        s_valid;
   logic        s_ready;
   logic [9:0]  s_data;
   logic        s_last;
   logic        tile_valid;
   logic        tile_ready;
   logic [69:0] D;
   logic        tile_last;
   logic        drop_pulse;

   int checks;
   int errors;
   int drop_count;

   wc_tile_feeder dut (
      .clk        (clk),
      .rst        (rst),
      .s_valid    (s_valid),
      .s_ready    (s_ready),
      .s_data     (s_data),
      .s_last     (s_last),
      .tile_valid (tile_valid),
      .tile_ready (tile_ready),
      .D          (D),
      .tile_last  (tile_last),
      .drop_pulse (drop_pulse)
   );

   // 10 ns clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Counts every cycle in which drop_pulse is high.
   initial drop_count = 0;
   always @(negedge clk) begin
      if (drop_pulse) drop_count = drop_count + 1;
   end

   // Compare one observed value with its expected value.
   task automatic checkOutput(input string tag, input logic [69:0] actual, input logic [69:0] expected);
      checks = checks + 1;
      if (actual !== expected) begin
         errors = errors + 1;
         $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
      end
   endtask

   // Build a tile from seven fields, f0 = oldest.
   function automatic logic [69:0] packTile(input logic [9:0] f0, input logic [9:0] f1,
                                            input logic [9:0] f2, input logic [9:0] f3,
                                            input logic [9:0] f4, input logic [9:0] f5,
                                            input logic [9:0] f6);
      return {f0, f1, f2, f3, f4, f5, f6};
   endfunction

   // Offer one sample and wait (bounded) until it is accepted.
   task automatic applyStimulus(input logic [9:0] d, input logic l);
      logic accepted;
      accepted = 1'b0;
      s_valid  = 1'b1;
      s_data   = d;
      s_last   = l;
      for (int n = 0; n < 50; n++) begin
         accepted = s_ready;
         @(posedge clk);
         #1;
         if (accepted) break;
      end
      s_valid = 1'b0;
      s_last  = 1'b0;
      if (!accepted) checkOutput("accept_timeout", {69'b0, accepted}, 70'd1);
   endtask

   // Wait (bounded) for tile_valid.
   task automatic waitTile(input string tag);
      for (int n = 0; n < 50; n++) begin
         if (tile_valid) break;
         @(posedge clk);
         #1;
      end
      checkOutput(tag, {69'b0, tile_valid}, 70'd1);
   endtask

   task automatic handoff();
      tile_ready = 1'b1;
      @(posedge clk);
      #1;
      tile_ready = 1'b0;
   endtask

   int drops_before;
   int tv_seen;
   logic [69:0] held;

   initial begin
      checks     = 0;
      errors     = 0;
      rst        = 1'b0;
      s_valid    = 1'b0;
      s_data     = '0;
      s_last     = 1'b0;
      tile_ready = 1'b0;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      checkOutput("rst_tile_valid", {69'b0, tile_valid}, 70'd0);
      checkOutput("rst_D", D, 70'd0);
      checkOutput("rst_s_ready", {69'b0, s_ready}, 70'd0);
      checkOutput("rst_tile_last", {69'b0, tile_last}, 70'd0);
      checkOutput("rst_drop", {69'b0, drop_pulse}, 70'd0);
      rst = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("post_rst_s_ready", {69'b0, s_ready}, 70'd1);

      // Single tile with signed samples, s_last on the completing sample
      applyStimulus(10'd2, 1'b0);
      applyStimulus(10'(-10), 1'b0);
      applyStimulus(10'd3, 1'b0);
      applyStimulus(10'd4, 1'b0);
      applyStimulus(10'(-13), 1'b0);
      applyStimulus(10'(-18), 1'b0);
      applyStimulus(10'(-16), 1'b1);
      checkOutput("vec_tile_valid_next", {69'b0, tile_valid}, 70'd1);
      checkOutput("vec_s_ready", {69'b0, s_ready}, 70'd0);
      checkOutput("vec_D", D,
         70'b0000000010_1111110110_0000000011_0000000100_1111110011_1111101110_1111110000);
      checkOutput("vec_tile_last", {69'b0, tile_last}, 70'd1);
      handoff();
      checkOutput("vec_cleared_D", D, 70'd0);
      checkOutput("vec_after_valid", {69'b0, tile_valid}, 70'd0);

      // 12 samples 0..11 -> two overlapping tiles
      for (int i = 0; i < 7; i++) applyStimulus(10'(i), 1'b0);
      waitTile("seq12_t0_valid");
      checkOutput("seq12_t0_D", D, packTile(0, 1, 2, 3, 4, 5, 6));
      checkOutput("seq12_t0_last", {69'b0, tile_last}, 70'd0);
      handoff();
      for (int i = 7; i < 12; i++) applyStimulus(10'(i), (i == 11));
      waitTile("seq12_t1_valid");
      checkOutput("seq12_t1_D", D, packTile(5, 6, 7, 8, 9, 10, 11));
      checkOutput("seq12_t1_last", {69'b0, tile_last}, 70'd1);
      handoff();

      // 9 samples, s_last on the 9th -> partial second tile
      drops_before = drop_count;
      for (int i = 0; i < 7; i++) applyStimulus(10'(i), 1'b0);
      waitTile("part_t0_valid");
      checkOutput("part_t0_D", D, packTile(0, 1, 2, 3, 4, 5, 6));
      checkOutput("part_t0_last", {69'b0, tile_last}, 70'd0);
      handoff();
      applyStimulus(10'd7, 1'b0);
      applyStimulus(10'd8, 1'b1);
`ifdef WC_FEED_ZPAD_EN
      waitTile("pad_t1_valid");
      checkOutput("pad_t1_D", D, packTile(5, 6, 7, 8, 0, 0, 0));
      checkOutput("pad_t1_last", {69'b0, tile_last}, 70'd1);
      handoff();
      checkOutput("pad_drop_count", 70'(drop_count - drops_before), 70'd0);
`else
      checkOutput("drop_pulse_now", {69'b0, drop_pulse}, 70'd1);
      checkOutput("drop_D_cleared", D, 70'd0);
      tv_seen = 0;
      for (int n = 0; n < 8; n++) begin
         @(posedge clk);
         #1;
         if (tile_valid) tv_seen = tv_seen + 1;
      end
      checkOutput("drop_no_tile", 70'(tv_seen), 70'd0);
      checkOutput("drop_count_one", 70'(drop_count - drops_before), 70'd1);
`endif

      // Backpressure: tile held for 10 cycles with a sample waiting
      for (int i = 0; i < 7; i++) applyStimulus(10'(i + 30), 1'b0);
      waitTile("bp_valid");
      held = packTile(30, 31, 32, 33, 34, 35, 36);
      s_valid = 1'b1;
      s_data  = 10'd99;
      for (int n = 0; n < 10; n++) begin
         checkOutput("bp_s_ready", {69'b0, s_ready}, 70'd0);
         checkOutput("bp_D_stable", D, held);
         checkOutput("bp_valid_held", {69'b0, tile_valid}, 70'd1);
         @(posedge clk);
         #1;
      end
      s_valid = 1'b0;
      handoff();
      checkOutput("bp_s_ready_after", {69'b0, s_ready}, 70'd1);
      checkOutput("bp_valid_after", {69'b0, tile_valid}, 70'd0);

      // Reset while a tile is held
      for (int i = 37; i < 42; i++) applyStimulus(10'(i), 1'b0);
      waitTile("rh_valid");
      checkOutput("rh_D", D, packTile(35, 36, 37, 38, 39, 40, 41));
      rst = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b1;
      checkOutput("rh_valid_cleared", {69'b0, tile_valid}, 70'd0);
      checkOutput("rh_D_cleared", D, 70'd0);
      for (int i = 0; i < 6; i++) applyStimulus(10'(i + 20), 1'b0);
      checkOutput("rh_no_early_tile", {69'b0, tile_valid}, 70'd0);
      applyStimulus(10'd26, 1'b1);
      waitTile("rh_new_valid");
      checkOutput("rh_new_D", D, packTile(20, 21, 22, 23, 24, 25, 26));
      checkOutput("rh_new_last", {69'b0, tile_last}, 70'd1);
      handoff();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
